// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the unified-memory arbiter: FSM states, requester tags,
// load/store size encodings and the access alignment check.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    IDLE    = 2'd1,
    RD_WAIT = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_FETCH = 2'd1,
    REQ_DATA  = 2'd2
  } req_id_t;

  typedef enum logic [2:0] {
    F3_BYTE  = 3'b000,
    F3_HALF  = 3'b001,
    F3_WORD  = 3'b010,
    F3_BYTEU = 3'b100,
    F3_HALFU = 3'b101
  } funct3_t;

  localparam funct3_t LOAD_STORE_FNS [5] = '{F3_BYTE, F3_HALF, F3_WORD, F3_BYTEU, F3_HALFU};

  localparam logic [31:0] OUTPORT_ADDR = 32'hFFFF_FFFC;

  // An unknown size encoding is rejected like a misaligned access so it never reaches memory.
  function automatic logic access_err(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic legal;
    legal = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (f3 == LOAD_STORE_FNS[i]) begin
        legal = 1'b1;
      end else begin
        legal = legal;
      end
    end
    case (f3[1:0])
      2'b00:   access_err = !legal;
      2'b01:   access_err = !legal || addr_lo[0];
      default: access_err = !legal || (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_rd_latency_pipe.sv
// Tracks the single in-flight read: a valid bit plus owner tag delayed by the memory
// read latency, so the tag pops out in the cycle mem_rd_data is valid.
module rd_latency_pipe
  import mem_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    in_valid,
  input  req_id_t in_id,
  output logic    out_valid,
  output req_id_t out_id
);

  logic [RD_LAT-1:0] valid_r;
  req_id_t           id_r [RD_LAT];

  // Shift register; reset drops any read in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= {RD_LAT{1'b0}};
      for (int i = 0; i < RD_LAT; i++) begin
        id_r[i] <= REQ_NONE;
      end
    end else begin
      valid_r[0] <= in_valid;
      id_r[0]    <= in_valid ? in_id : REQ_NONE;
      for (int i = 1; i < RD_LAT; i++) begin
        valid_r[i] <= valid_r[i-1];
        id_r[i]    <= id_r[i-1];
      end
    end
  end

  assign out_valid = valid_r[RD_LAT-1];
  assign out_id    = id_r[RD_LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// Unified-memory arbiter: flash-only boot phase, then data/fetch arbitration with a
// fetch starvation guard and a single read in flight.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fl_req,
  input  logic [WIDTH-1:0] fl_addr,
  input  logic [WIDTH-1:0] fl_data,
  input  logic             fl_done,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [WIDTH-1:0] if_rdata,
  output logic             if_err,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  input  logic [2:0]       d_funct3,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_err,
  output logic             boot_busy,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_wren,
  output logic [WIDTH-1:0] mem_wr_data,
  output logic [2:0]       mem_funct3,
  output logic             mem_flash_en,
  input  logic [WIDTH-1:0] mem_rd_data
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  arb_state_t       state_r;
  arb_state_t       state_nxt_s;
  logic [CNT_W-1:0] starve_cnt_r;
  logic [WIDTH-1:0] hold_addr_r;
  logic [2:0]       hold_f3_r;

  logic    arb_en_s;
  logic    fetch_pick_s;
  logic    d_gnt_s;
  logic    if_gnt_s;
  logic    d_err_s;
  logic    if_err_s;
  logic    rd_issue_s;
  req_id_t rd_id_s;
  logic    pipe_valid_s;
  req_id_t pipe_id_s;

  // The rvalid cycle of a read doubles as an arbitration cycle.
  assign arb_en_s     = (state_r == IDLE) || ((state_r == RD_WAIT) && pipe_valid_s);
  assign fetch_pick_s = if_req && (!d_req || (starve_cnt_r == CNT_W'(STARVE_MAX)));
  assign d_gnt_s      = arb_en_s && d_req && !fetch_pick_s;
  assign if_gnt_s     = arb_en_s && fetch_pick_s;
  assign d_err_s      = d_gnt_s && access_err(d_funct3, d_addr[1:0]);
  assign if_err_s     = if_gnt_s && (if_addr[1:0] != 2'b00);
  assign rd_issue_s   = (d_gnt_s && !d_we && !d_err_s) || (if_gnt_s && !if_err_s);
  assign rd_id_s      = if_gnt_s ? REQ_FETCH : REQ_DATA;

  rd_latency_pipe #(.RD_LAT(RD_LAT)) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_issue_s),
    .in_id     (rd_id_s),
    .out_valid (pipe_valid_s),
    .out_id    (pipe_id_s)
  );

  // State register, starvation counter and read address/size hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= BOOT;
      starve_cnt_r <= {CNT_W{1'b0}};
      hold_addr_r  <= {WIDTH{1'b0}};
      hold_f3_r    <= 3'b000;
    end else begin
      state_r <= state_nxt_s;
      if (if_gnt_s || !if_req) begin
        starve_cnt_r <= {CNT_W{1'b0}};
      end else if (d_gnt_s && (starve_cnt_r < CNT_W'(STARVE_MAX))) begin
        starve_cnt_r <= starve_cnt_r + CNT_W'(1);
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
      if (rd_issue_s) begin
        hold_addr_r <= if_gnt_s ? if_addr : d_addr;
        hold_f3_r   <= if_gnt_s ? 3'(F3_WORD) : d_funct3;
      end else begin
        hold_addr_r <= hold_addr_r;
        hold_f3_r   <= hold_f3_r;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      BOOT:    state_nxt_s = fl_done ? IDLE : BOOT;
      IDLE:    state_nxt_s = rd_issue_s ? RD_WAIT : IDLE;
      RD_WAIT: begin
        if (pipe_valid_s) begin
          state_nxt_s = rd_issue_s ? RD_WAIT : IDLE;
        end else begin
          state_nxt_s = RD_WAIT;
        end
      end
      default: state_nxt_s = BOOT;
    endcase
  end

  // Memory-side drive: flash in BOOT, the granted requester, else the held read
  always_comb begin
    mem_addr     = {WIDTH{1'b0}};
    mem_wr_data  = {WIDTH{1'b0}};
    mem_funct3   = 3'b000;
    mem_wren     = 1'b0;
    mem_flash_en = 1'b0;
    case (state_r)
      BOOT: begin
        if (fl_req) begin
          mem_flash_en = 1'b1;
          mem_addr     = fl_addr;
          mem_wr_data  = fl_data;
          mem_funct3   = 3'(F3_WORD);
        end else begin
          mem_flash_en = 1'b0;
        end
      end
      IDLE, RD_WAIT: begin
        if (d_gnt_s && !d_err_s) begin
          mem_addr    = d_addr;
          mem_funct3  = d_funct3;
          mem_wren    = d_we;
          mem_wr_data = d_we ? d_wdata : {WIDTH{1'b0}};
        end else if (if_gnt_s && !if_err_s) begin
          mem_addr   = if_addr;
          mem_funct3 = 3'(F3_WORD);
        end else if (state_r == RD_WAIT) begin
          mem_addr   = hold_addr_r;
          mem_funct3 = hold_f3_r;
        end else begin
          mem_addr = {WIDTH{1'b0}};
        end
      end
      default: mem_wren = 1'b0;
    endcase
  end

  assign boot_busy = (state_r == BOOT);
  assign d_gnt     = d_gnt_s;
  assign if_gnt    = if_gnt_s;
  assign d_err     = d_err_s;
  assign if_err    = if_err_s;
  assign d_rvalid  = pipe_valid_s && (pipe_id_s == REQ_DATA);
  assign if_rvalid = pipe_valid_s && (pipe_id_s == REQ_FETCH);
  assign d_rdata   = d_rvalid ? mem_rd_data : {WIDTH{1'b0}};
  assign if_rdata  = if_rvalid ? mem_rd_data : {WIDTH{1'b0}};

endmodule
